pad_bidir_ctrl: RTL
===================

// Module: pad_bidir_ctrl
// PURPOSE
// Core-side controller for one bidirectional IO pad (c2p/c2p_en/p2c pad ports).
// Drive path: sequences pad direction with a guaranteed bus-turnaround gap and registers drive data.
// Receive path: synchronises, deglitches and edge-detects the pad input, and blanks it while the
// pad is driven or turning around. Sits between core logic and the pad instance, one per pad.
// PARAMETERS
// SYNC_STAGES  2  p2c synchroniser depth; must be >= 2.
// FILT_LEN     4  consecutive equal samples needed to accept a new input level; >= 1 (1 = no filter).
// TURN_CYC     3  turnaround gap in cycles with c2p_en=0; must be >= SYNC_STAGES.
// PORTS
// clk       in   1  clock; all logic on the rising edge.
// rst       in   1  synchronous, active-high reset.
// drv_req   in   1  1 = core requests drive mode, 0 = requests receive mode.
// drv_data  in   1  value to drive onto the pad while in drive mode.
// c2p       out  1  to pad c2p.
// c2p_en    out  1  to pad c2p_en; pad output enable.
// p2c       in   1  from pad p2c; asynchronous.
// mode_drv  out  1  1 while settled in drive mode (state TX).
// busy      out  1  1 during turnaround (RX2TX, TX2RX).
// in_level  out  1  filtered input level.
// in_valid  out  1  in_level is meaningful (state RX only).
// in_rise   out  1  one-cycle pulse when in_level goes 0->1 with in_valid=1.
// in_fall   out  1  one-cycle pulse when in_level goes 1->0 with in_valid=1.
// BEHAVIOUR
// - All outputs are registered. Counter widths are $clog2(max count + 1).
// - Reset: state=TX2RX, turn count=0, sync chain=0, filter count=0.
//   Outputs: c2p=0, c2p_en=0, mode_drv=0, busy=1, in_level=0, in_valid=0, in_rise=0, in_fall=0.
// - Synchroniser: p2c passes through SYNC_STAGES flops; the last stage is s.
// - Filter: when s != in_level, the filter count increments. When s differs for FILT_LEN consecutive
//   cycles, in_level<=s and the count clears. Any cycle with s==in_level clears the count.
//   A clean p2c edge reaches in_level SYNC_STAGES+FILT_LEN cycles later.
// - Edge pulses fire in the cycle in_level changes, only if in_valid=1 in that cycle.
// - FSM (next state evaluated from drv_req sampled at cycle end):
//   RX:     in_valid=1, c2p_en=0. drv_req=1 -> RX2TX, turn count=0, in_valid=0.
//   RX2TX:  c2p_en=0, busy=1. drv_req=0 -> RX (abort, same load as RX entry).
//           Otherwise after TURN_CYC cycles in RX2TX -> TX.
//   TX:     c2p_en=1, mode_drv=1. c2p<=drv_data each cycle (1-cycle latency).
//           drv_req=0 -> TX2RX.
//   TX2RX:  c2p_en=0, c2p=0, busy=1. Always completes TURN_CYC cycles, then -> RX.
//           drv_req is ignored here; a re-request is acted on from RX.
// - RX entry (from TX2RX or an RX2TX abort): in_level<=s, filter count clears, in_valid<=1.
//   No edge pulse is generated on that load.
// - Filter and synchroniser run in every state. in_rise/in_fall=0 whenever in_valid=0.
// - Drive-request timing: drv_req=1 sampled at end of cycle N -> busy=1 in cycles N+1..N+TURN_CYC;
//   c2p_en=1 and mode_drv=1 from N+TURN_CYC+1.
// - Release timing: drv_req=0 sampled at end of cycle M -> c2p_en=0 from M+1;
//   in_valid=1 from M+TURN_CYC+1.
// - Reset mid-operation: the next cycle shows reset values, including c2p_en=0.
//   After reset release the block follows the TX2RX path to RX.
// TESTING
// 1. p2c=1 held, rst high 3 cycles then low -> busy=1 and c2p_en=0 for 3 cycles;
//    then in_valid=1, in_level=1, no in_rise pulse.
// 2. In RX with in_level=0: p2c high for 3 cycles -> no change. p2c high for >=4 cycles ->
//    in_level=1 and a single in_rise pulse 6 cycles after the p2c rise.
// 3. drv_req 0->1 at cycle N -> c2p_en=0 through N+3, c2p_en=1 and mode_drv=1 at N+4;
//    toggling drv_data appears on c2p one cycle later.
// 4. drv_req high for only 2 cycles -> returns to RX; c2p_en never 1; in_valid=1 with no edge pulse.
// 5. In TX, drop drv_req while p2c toggles -> c2p_en=0 next cycle; in_valid=0 for 3 cycles;
//    no in_rise/in_fall during TX or turnaround; in_level loaded on RX entry.
// 6. Assert rst while c2p_en=1, c2p=1 -> next cycle c2p_en=0, c2p=0, busy=1, in_valid=0.

Source files
------------

// File: rtl/pad_bidir_ctrl.sv
// Core-side controller for one bidirectional pad: sequences drive/receive direction with a
// turnaround gap, and synchronises, deglitches and edge-detects the pad input.
module pad_bidir_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TURN_CYC    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic drv_req,
    input  logic drv_data,
    output logic c2p,
    output logic c2p_en,
    input  logic p2c,
    output logic mode_drv,
    output logic busy,
    output logic in_level,
    output logic in_valid,
    output logic in_rise,
    output logic in_fall
);

    localparam logic [1:0] ST_RX    = 2'd0;
    localparam logic [1:0] ST_RX2TX = 2'd1;
    localparam logic [1:0] ST_TX    = 2'd2;
    localparam logic [1:0] ST_TX2RX = 2'd3;

    localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam int FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);

    logic [1:0]             state_reg, state_next;
    logic [TURN_W-1:0]      turn_reg, turn_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [FILT_W-1:0]      filt_reg, filt_next;
    logic                   level_reg, level_next;
    logic                   c2p_reg, c2p_en_reg, mode_drv_reg, busy_reg;
    logic                   valid_reg, rise_reg, fall_reg;
    logic                   rx_entry, accept, s;
    logic                   valid_next, rise_next, fall_next;

    assign s = sync_reg[SYNC_STAGES-1];

    // Direction sequencer: both turnarounds run TURN_CYC cycles with the pad driver off.
    always_comb begin
        state_next = state_reg;
        turn_next  = turn_reg;
        rx_entry   = 1'b0;
        case (state_reg)
            ST_RX: begin
                if (drv_req) begin
                    state_next = ST_RX2TX;
                    turn_next  = '0;
                end
            end
            ST_RX2TX: begin
                if (!drv_req) begin
                    state_next = ST_RX;
                    rx_entry   = 1'b1;
                end else if (turn_reg == TURN_LAST) begin
                    state_next = ST_TX;
                    turn_next  = '0;
                end else begin
                    turn_next = turn_reg + 1'b1;
                end
            end
            ST_TX: begin
                if (!drv_req) begin
                    state_next = ST_TX2RX;
                    turn_next  = '0;
                end
            end
            ST_TX2RX: begin
                if (turn_reg == TURN_LAST) begin
                    state_next = ST_RX;
                    rx_entry   = 1'b1;
                    turn_next  = '0;
                end else begin
                    turn_next = turn_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_TX2RX;
                turn_next  = '0;
            end
        endcase
    end

    // Deglitch filter; entering RX snaps the level to the current sample without an edge pulse.
    always_comb begin
        level_next = level_reg;
        filt_next  = filt_reg;
        accept     = 1'b0;
        if (rx_entry) begin
            level_next = s;
            filt_next  = '0;
        end else if (s != level_reg) begin
            if (filt_reg == FILT_LAST) begin
                level_next = s;
                filt_next  = '0;
                accept     = 1'b1;
            end else begin
                filt_next = filt_reg + 1'b1;
            end
        end else begin
            filt_next = '0;
        end
    end

    assign valid_next = (state_next == ST_RX);
    assign rise_next  = accept & valid_next & s;
    assign fall_next  = accept & valid_next & ~s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_TX2RX;
            turn_reg     <= '0;
            sync_reg     <= '0;
            filt_reg     <= '0;
            level_reg    <= 1'b0;
            c2p_reg      <= 1'b0;
            c2p_en_reg   <= 1'b0;
            mode_drv_reg <= 1'b0;
            busy_reg     <= 1'b1;
            valid_reg    <= 1'b0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            turn_reg     <= turn_next;
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], p2c};
            filt_reg     <= filt_next;
            level_reg    <= level_next;
            c2p_reg      <= (state_next == ST_TX) & drv_data;
            c2p_en_reg   <= (state_next == ST_TX);
            mode_drv_reg <= (state_next == ST_TX);
            busy_reg     <= (state_next == ST_RX2TX) | (state_next == ST_TX2RX);
            valid_reg    <= valid_next;
            rise_reg     <= rise_next;
            fall_reg     <= fall_next;
        end
    end

    assign c2p      = c2p_reg;
    assign c2p_en   = c2p_en_reg;
    assign mode_drv = mode_drv_reg;
    assign busy     = busy_reg;
    assign in_level = level_reg;
    assign in_valid = valid_reg;
    assign in_rise  = rise_reg;
    assign in_fall  = fall_reg;

endmodule
